// File: rtl/gp0_axil_fifo_shell.sv
// rtl/gp0_axil_fifo_shell.sv - AXI4-Lite register shell with PS->PL and PL->PS word FIFOs
//
// Purpose: exposes two 32-bit control registers and two small word FIFOs to a
// processor over AXI4-Lite. addr[4:2] selects the target:
//   0 CSR0 (RW, byte-masked)       1 CSR1 (RW, byte-masked)
//   2 ps_to_pl push (WO)           3 ps_to_pl free slots (RO)
//   4 pl_to_ps pop (RO)            5 pl_to_ps occupancy (RO)
//   6-7 unmapped (SLVERR)
//
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   s00_axi_aw*/w*/b*           AXI4-Lite write address, data and response channels
//   s00_axi_ar*/r*              AXI4-Lite read address and data channels
//   pl_to_ps_data_i/v_i/ready_o PL producer side of the pl_to_ps FIFO (ready-valid)
//   ps_to_pl_data_o/v_o/yumi_i  PL consumer side of the ps_to_pl FIFO (valid-yumi)
//   csr_data_o                  {CSR1, CSR0}

module gp0_axil_fifo_shell #(
   parameter int C_GP0_AXI_DATA_WIDTH = 32,
   parameter int C_GP0_AXI_ADDR_WIDTH = 10,
   parameter int FIFO_ELS             = 4
) (
   input  logic                              aclk,
   input  logic                              aresetn,

   input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_GP0_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_GP0_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_GP0_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,

   input  logic [31:0]                       pl_to_ps_data_i,
   input  logic                              pl_to_ps_v_i,
   output logic                              pl_to_ps_ready_o,

   output logic [31:0]                       ps_to_pl_data_o,
   output logic                              ps_to_pl_v_o,
   input  logic                              ps_to_pl_yumi_i,

   output logic [63:0]                       csr_data_o
);

   localparam int DW = C_GP0_AXI_DATA_WIDTH;
   localparam int PW = (FIFO_ELS > 1) ? $clog2(FIFO_ELS) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH  = CW'(FIFO_ELS);
   localparam logic [1:0]    OKAY   = 2'b00;
   localparam logic [1:0]    SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   w_state_e w_state, w_next;
   r_state_e r_state, r_next;

   logic          w_hs, ar_hs;
   logic [2:0]    w_idx, r_idx;
   logic [DW-1:0] csr0, csr1;
   logic [DW-1:0] rd_word;
   logic          rd_err;

   // pl_to_ps FIFO (PL pushes, AXI read of addr 4 pops)
   logic [31:0]   p2s_mem [FIFO_ELS];
   logic [PW-1:0] p2s_wp, p2s_rp;
   logic [CW-1:0] p2s_cnt;
   logic          p2s_full, p2s_empty, p2s_push, p2s_pop;

   // ps_to_pl FIFO (AXI write of addr 2 pushes, PL yumi pops)
   logic [31:0]   s2p_mem [FIFO_ELS];
   logic [PW-1:0] s2p_wp, s2p_rp;
   logic [CW-1:0] s2p_cnt;
   logic          s2p_full, s2p_empty, s2p_push, s2p_pop;

   // Only addr[4:2] is decoded; protection bits carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[C_GP0_AXI_ADDR_WIDTH-1:5], s00_axi_awaddr[1:0],
                        s00_axi_araddr[C_GP0_AXI_ADDR_WIDTH-1:5], s00_axi_araddr[1:0]};

   assign w_idx = s00_axi_awaddr[4:2];
   assign r_idx = s00_axi_araddr[4:2];

   // ---------------- write channel FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // aw and w are accepted together so no address/data pairing buffer is needed.
   always_comb begin
      w_next          = w_state;
      s00_axi_awready = 1'b0;
      s00_axi_wready  = 1'b0;
      s00_axi_bvalid  = 1'b0;
      w_hs            = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aresetn && s00_axi_awvalid && s00_axi_wvalid) begin
               s00_axi_awready = 1'b1;
               s00_axi_wready  = 1'b1;
               w_hs            = 1'b1;
               w_next          = W_RESP;
            end
         end
         W_RESP: begin
            s00_axi_bvalid = 1'b1;
            if (s00_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         csr0          <= '0;
         csr1          <= '0;
         s00_axi_bresp <= OKAY;
      end else if (w_hs) begin
         case (w_idx)
            3'd0: begin
               for (int i = 0; i < DW/8; i++)
                  if (s00_axi_wstrb[i]) csr0[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
               s00_axi_bresp <= OKAY;
            end
            3'd1: begin
               for (int i = 0; i < DW/8; i++)
                  if (s00_axi_wstrb[i]) csr1[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
               s00_axi_bresp <= OKAY;
            end
            3'd2:    s00_axi_bresp <= s2p_full ? SLVERR : OKAY;
            default: s00_axi_bresp <= SLVERR;
         endcase
      end
   end

   // ---------------- read channel FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   always_comb begin
      r_next          = r_state;
      s00_axi_arready = 1'b0;
      s00_axi_rvalid  = 1'b0;
      ar_hs           = 1'b0;
      case (r_state)
         R_IDLE: begin
            s00_axi_arready = aresetn;
            if (aresetn && s00_axi_arvalid) begin
               ar_hs  = 1'b1;
               r_next = R_RESP;
            end
         end
         R_RESP: begin
            s00_axi_rvalid = 1'b1;
            if (s00_axi_rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Read data is taken from pre-edge state, so a same-cycle CSR write is not
   // visible to the read that shares its edge.
   always_comb begin
      rd_word = '0;
      rd_err  = 1'b0;
      p2s_pop = 1'b0;
      case (r_idx)
         3'd0: rd_word = csr0;
         3'd1: rd_word = csr1;
         3'd3: rd_word = DW'(DEPTH - s2p_cnt);
         3'd4: begin
            if (!p2s_empty) begin
               rd_word = p2s_mem[p2s_rp];
               p2s_pop = ar_hs;
            end else begin
               rd_err  = 1'b1;
            end
         end
         3'd5:    rd_word = DW'(p2s_cnt);
         default: rd_err  = 1'b1;   // 2 is write-only; 6-7 unmapped
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s00_axi_rdata <= '0;
         s00_axi_rresp <= OKAY;
      end else if (ar_hs) begin
         s00_axi_rdata <= rd_word;
         s00_axi_rresp <= rd_err ? SLVERR : OKAY;
      end
   end

   // ---------------- pl_to_ps FIFO ----------------
   assign p2s_full         = (p2s_cnt == DEPTH);
   assign p2s_empty        = (p2s_cnt == '0);
   // Ready depends on stored count only, so a pop never frees a slot in the
   // same cycle; a push to a full FIFO waits one cycle.
   assign pl_to_ps_ready_o = aresetn && !p2s_full;
   assign p2s_push         = pl_to_ps_v_i && pl_to_ps_ready_o;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         p2s_wp  <= '0;
         p2s_rp  <= '0;
         p2s_cnt <= '0;
      end else begin
         if (p2s_push) p2s_wp <= p2s_wp + PW'(1);
         if (p2s_pop)  p2s_rp <= p2s_rp + PW'(1);
         p2s_cnt <= p2s_cnt + CW'(p2s_push) - CW'(p2s_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (p2s_push) p2s_mem[p2s_wp] <= pl_to_ps_data_i;
   end

   // ---------------- ps_to_pl FIFO ----------------
   assign s2p_full        = (s2p_cnt == DEPTH);
   assign s2p_empty       = (s2p_cnt == '0);
   assign s2p_push        = w_hs && (w_idx == 3'd2) && !s2p_full;
   assign s2p_pop         = ps_to_pl_yumi_i && !s2p_empty;
   assign ps_to_pl_v_o    = !s2p_empty;
   assign ps_to_pl_data_o = s2p_mem[s2p_rp];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s2p_wp  <= '0;
         s2p_rp  <= '0;
         s2p_cnt <= '0;
      end else begin
         if (s2p_push) s2p_wp <= s2p_wp + PW'(1);
         if (s2p_pop)  s2p_rp <= s2p_rp + PW'(1);
         s2p_cnt <= s2p_cnt + CW'(s2p_push) - CW'(s2p_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (s2p_push) s2p_mem[s2p_wp] <= s00_axi_wdata[31:0];
   end

   assign csr_data_o = {csr1[31:0], csr0[31:0]};

endmodule

// File: tb/tb_gp0_axil_fifo_shell.sv
// tb/tb_gp0_axil_fifo_shell.sv - scoreboard bench for gp0_axil_fifo_shell
module tb_gp0_axil_fifo_shell;

   localparam int ELS = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [9:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [9:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] pl_data = '0;
   logic        pl_v = 1'b0;
   logic        pl_ready;
   logic [31:0] ps_data;
   logic        ps_v;
   logic        yumi = 1'b0;
   logic [63:0] csr_data;

   gp0_axil_fifo_shell #(
      .C_GP0_AXI_DATA_WIDTH(32), .C_GP0_AXI_ADDR_WIDTH(10), .FIFO_ELS(ELS)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
      .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
      .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
      .s00_axi_rready(rready),
      .pl_to_ps_data_i(pl_data), .pl_to_ps_v_i(pl_v), .pl_to_ps_ready_o(pl_ready),
      .ps_to_pl_data_o(ps_data), .ps_to_pl_v_o(ps_v), .ps_to_pl_yumi_i(yumi),
      .csr_data_o(csr_data)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0] m_csr0 = '0, m_csr1 = '0;
   logic [31:0] pl_q[$];
   logic [31:0] ps_q[$];
   logic [1:0]  bq[$];
   logic [31:0] rq_d[$];
   logic [1:0]  rq_r[$];
   bit          b_pend = 0, r_pend = 0;
   logic [1:0]  last_bresp = '0;
   logic [31:0] last_rdata = '0;
   logic [1:0]  last_rresp = '0;

   // stimulus modes: bmode/rmode 0 random, 1 always ready, 2 hold low
   bit pl_mode = 0, yumi_mode = 0;
   int bmode = 1, rmode = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // background drivers
   always @(negedge aclk) begin
      if (pl_mode) begin
         pl_v    = 1'($urandom_range(0, 1));
         pl_data = $urandom;
      end
      if (yumi_mode) yumi = (ps_q.size() != 0) && ($urandom_range(0, 1) == 1);
      bready = (bmode == 0) ? 1'($urandom_range(0, 1)) : (bmode == 1);
      rready = (rmode == 0) ? 1'($urandom_range(0, 1)) : (rmode == 1);
   end

   // Monitor + reference model: evaluated mid-low-phase for the coming rising edge.
   always @(negedge aclk) begin : model
      logic        w_hs, r_hs, pl_acc, ps_full;
      logic [31:0] ed;
      logic [1:0]  er;
      #2;
      if (aresetn) begin
         chk("pl_ready", pl_ready, pl_q.size() < ELS);
         chk("ps_v", ps_v, ps_q.size() != 0);
         if (ps_q.size() != 0) chk("ps_data", ps_data, ps_q[0]);
         chk("csr_data", csr_data, {m_csr1, m_csr0});
         chk("awready", awready, !b_pend && awvalid && wvalid);
         chk("wready", wready, !b_pend && awvalid && wvalid);
         chk("arready", arready, !r_pend);
         chk("bvalid", bvalid, b_pend);
         chk("rvalid", rvalid, r_pend);
         if (bvalid && bq.size() != 0) chk("bresp", bresp, bq[0]);
         if (rvalid && rq_d.size() != 0) begin
            chk("rdata", rdata, rq_d[0]);
            chk("rresp", rresp, rq_r[0]);
         end

         w_hs    = awvalid && wvalid && !b_pend;
         r_hs    = arvalid && !r_pend;
         pl_acc  = pl_v && (pl_q.size() < ELS);
         ps_full = (ps_q.size() >= ELS);

         if (r_hs) begin
            ed = 0; er = 2'b00;
            case (araddr[4:2])
               3'd0: ed = m_csr0;
               3'd1: ed = m_csr1;
               3'd3: ed = ELS - ps_q.size();
               3'd4: if (pl_q.size() != 0) ed = pl_q.pop_front(); else er = 2'b10;
               3'd5: ed = pl_q.size();
               default: er = 2'b10;
            endcase
            rq_d.push_back(ed);
            rq_r.push_back(er);
         end
         if (yumi && ps_q.size() != 0) void'(ps_q.pop_front());
         if (w_hs) begin
            case (awaddr[4:2])
               3'd0: begin m_csr0 = merge(m_csr0, wdata, wstrb); bq.push_back(2'b00); end
               3'd1: begin m_csr1 = merge(m_csr1, wdata, wstrb); bq.push_back(2'b00); end
               3'd2: if (ps_full) bq.push_back(2'b10);
                     else begin ps_q.push_back(wdata); bq.push_back(2'b00); end
               default: bq.push_back(2'b10);
            endcase
         end
         if (pl_acc) pl_q.push_back(pl_data);

         if (b_pend && bready) begin
            last_bresp = bresp;
            if (bq.size() != 0) void'(bq.pop_front());
            b_pend = 0;
         end
         if (r_pend && rready) begin
            last_rdata = rdata;
            last_rresp = rresp;
            if (rq_d.size() != 0) begin void'(rq_d.pop_front()); void'(rq_r.pop_front()); end
            r_pend = 0;
         end
         if (w_hs) b_pend = 1;
         if (r_hs) r_pend = 1;
      end
   end

   task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      int t = 0;
      @(negedge aclk);
      awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
      awvalid = 1; wvalid = 1;
      #2;
      while (!awready) begin
         if (++t > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL aw_timeout: awready never seen for addr %0h", a);
            break;
         end
         @(negedge aclk); #2;
      end
      @(negedge aclk);
      awvalid = 0; wvalid = 0;
   endtask

   task automatic axi_read(input logic [9:0] a);
      int t = 0;
      @(negedge aclk);
      araddr = a; arprot = 3'($urandom); arvalid = 1;
      #2;
      while (!arready) begin
         if (++t > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL ar_timeout: arready never seen for addr %0h", a);
            break;
         end
         @(negedge aclk); #2;
      end
      @(negedge aclk);
      arvalid = 0;
   endtask

   task automatic pl_push(input logic [31:0] d);
      int t = 0;
      @(negedge aclk);
      pl_data = d; pl_v = 1;
      #2;
      while (!pl_ready) begin
         if (++t > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL pl_timeout: ready_o never seen for %0h", d);
            break;
         end
         @(negedge aclk); #2;
      end
      @(negedge aclk);
      pl_v = 0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge aclk); #3;
      while (b_pend || r_pend || bq.size() != 0 || rq_d.size() != 0) begin
         if (++t > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL idle_timeout: responses outstanding b=%0d r=%0d", b_pend, r_pend);
            break;
         end
         @(negedge aclk); #3;
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_awready"}, awready, 0);
      chk({tag, "_wready"}, wready, 0);
      chk({tag, "_arready"}, arready, 0);
      chk({tag, "_bvalid"}, bvalid, 0);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_pl_ready"}, pl_ready, 0);
      chk({tag, "_ps_v"}, ps_v, 0);
      chk({tag, "_csr"}, csr_data, 0);
      chk({tag, "_bresp"}, bresp, 0);
      chk({tag, "_rresp"}, rresp, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask

   task automatic clear_model();
      pl_q.delete(); ps_q.delete(); bq.delete(); rq_d.delete(); rq_r.delete();
      b_pend = 0; r_pend = 0; m_csr0 = '0; m_csr1 = '0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t;
      aresetn = 1'b1;
      #1 aresetn = 1'b0;
      awvalid = 1; wvalid = 1; arvalid = 1; pl_v = 1;
      repeat (2) @(negedge aclk);
      #2 reset_checks("reset");
      awvalid = 0; wvalid = 0; arvalid = 0; pl_v = 0;
      @(negedge aclk); #1 aresetn = 1'b1;

      // byte-masked CSR write, read back
      axi_write(10'h000, 32'hA5A5_5A5A, 4'h3);
      axi_read(10'h000);
      wait_idle();
      chk("csr0_bresp", last_bresp, 2'b00);
      chk("csr0_rdata", last_rdata, 32'h0000_5A5A);
      chk("csr0_out", csr_data[31:0], 32'h0000_5A5A);

      // ps_to_pl overflow
      for (int i = 0; i < 5; i++) axi_write(10'h008, 32'h1000 + i, 4'h0);
      wait_idle();
      chk("push5_bresp", last_bresp, 2'b10);
      axi_read(10'h00C);
      wait_idle();
      chk("free_full", last_rdata, 0);
      chk("ps_v_full", ps_v, 1);
      chk("ps_head", ps_data, 32'h1000);
      @(negedge aclk); yumi = 1;
      repeat (4) @(negedge aclk);
      yumi = 0;
      #2 chk("ps_drained", ps_v, 0);

      // pl_to_ps empty pop, then single word
      axi_read(10'h010);
      wait_idle();
      chk("pop_empty_data", last_rdata, 0);
      chk("pop_empty_resp", last_rresp, 2'b10);
      pl_push(32'h1234);
      axi_read(10'h014);
      wait_idle();
      chk("occ_one", last_rdata, 1);
      axi_read(10'h010);
      wait_idle();
      chk("pop_data", last_rdata, 32'h1234);
      chk("pop_resp", last_rresp, 2'b00);

      // full pl_to_ps: pop while PL is pushing
      for (int i = 0; i < 4; i++) pl_push(32'h100 + i);
      @(negedge aclk); #2 chk("p2s_full_ready", pl_ready, 0);
      pl_data = 32'h104; pl_v = 1;
      axi_read(10'h010);
      wait_idle();
      @(negedge aclk); pl_v = 0;
      axi_read(10'h014);
      wait_idle();
      chk("occ_refill", last_rdata, 4);
      chk("refill_ready", pl_ready, 0);
      for (int i = 0; i < 4; i++) begin
         axi_read(10'h010);
         wait_idle();
         chk("order", last_rdata, 32'h101 + i);
      end

      // stalled write response while a read completes
      bmode = 2;
      fork
         axi_write(10'h004, 32'hDEAD_BEEF, 4'hF);
         axi_read(10'h000);
      join
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk); #3;
         chk("b_held", bvalid, 1);
         chk("b_stable", bresp, 2'b00);
      end
      chk("read_done", r_pend, 0);
      chk("read_val", last_rdata, 32'h0000_5A5A);
      bmode = 1;
      wait_idle();

      // randomized concurrent traffic
      pl_mode = 1; yumi_mode = 1; bmode = 0; rmode = 0;
      fork
         for (int i = 0; i < 150; i++)
            axi_write(10'($urandom), $urandom, 4'($urandom));
         for (int i = 0; i < 150; i++)
            axi_read(10'($urandom_range(0, 7) << 2));
      join
      @(negedge aclk);
      pl_mode = 0; yumi_mode = 0; pl_v = 0; yumi = 0; bmode = 1; rmode = 1;
      wait_idle();

      // reset while a read response is pending
      axi_write(10'h000, 32'h0BAD_F00D, 4'hF);
      wait_idle();
      if (pl_q.size() < ELS) pl_push(32'h55);
      rmode = 2;
      axi_read(10'h014);
      t = 0;
      while (!rvalid && t < 50) begin @(negedge aclk); t++; end
      chk("rvalid_before_reset", rvalid, 1);
      @(negedge aclk); #3 aresetn = 1'b0;
      #1 reset_checks("midreset");
      clear_model();
      rmode = 1;
      repeat (2) @(negedge aclk);
      #1 aresetn = 1'b1;
      axi_read(10'h014);
      wait_idle();
      chk("occ_after_reset", last_rdata, 0);
      chk("occ_after_reset_resp", last_rresp, 2'b00);

      repeat (2) @(negedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gp0_axil_fifo_shell.md
GP0_AXIL_FIFO_SHELL -- requirements
Module: gp0_axil_fifo_shell

Interface
REQ-001 SHALL have parameter C_GP0_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width; only 32 is legal.
REQ-002 SHALL have parameter C_GP0_AXI_ADDR_WIDTH, default 10, the AXI4-Lite byte address width; only bits [4:2] are decoded.
REQ-003 SHALL have parameter FIFO_ELS, default 4, the depth of each FIFO; must be a power of 2, minimum 2.
REQ-004 One clock; reset is asynchronous and active-low: aclk, aresetn.
REQ-005 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 aresetn  in  1  async active-low reset.
REQ-007 s00_axi_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready  AXI4-Lite slave; widths per parameters; prot inputs ignored.
REQ-008 pl_to_ps_data_i  in  32  PL-produced word; pl_to_ps_v_i  in  1; pl_to_ps_ready_o  out  1  (ready-valid).
REQ-009 ps_to_pl_data_o  out  32; ps_to_pl_v_o  out  1; ps_to_pl_yumi_i  in  1  consume, legal only when v_o=1.
REQ-010 csr_data_o  out  64  {CSR1, CSR0}.

Function
REQ-011 Address map by addr[4:2]: 0 CSR0 RW; 1 CSR1 RW; 2 ps_to_pl FIFO push (WO); 3 ps_to_pl free slots (RO); 4 pl_to_ps FIFO pop (RO); 5 pl_to_ps occupancy (RO); 6-7 unmapped.
REQ-012 Write FSM states W_IDLE, W_RESP; in W_IDLE awready=wready=1 only in a cycle where awvalid and wvalid are both 1, and the transfer completes in that cycle.
REQ-013 On the write handshake in cycle N, the FSM SHALL move to W_RESP with bvalid=1 from cycle N+1, held with stable bresp until bready; then return to W_IDLE.
REQ-014 CSR writes SHALL be byte-masked by wstrb.
REQ-015 FIFO push writes ignore wstrb.
REQ-016 A push to a full ps_to_pl FIFO SHALL be dropped with bresp=2'b10.
REQ-017 A write to a RO or unmapped address SHALL change no state and return bresp=2'b10.
REQ-018 All other writes SHALL return bresp=2'b00.
REQ-019 Read FSM states R_IDLE, R_RESP; in R_IDLE arready=1 every cycle.
REQ-020 On the ar handshake in cycle N, rdata/rresp SHALL be registered and rvalid=1 from cycle N+1, held stable until rready; then return to R_IDLE.
REQ-021 A read of addr 4 SHALL pop the pl_to_ps FIFO in the ar handshake cycle.
REQ-022 A read of addr 4 when the FIFO is empty SHALL return rdata=0, rresp=2'b10, with no pop.
REQ-023 A read of an unmapped address SHALL return rdata=0, rresp=2'b10.
REQ-024 Occupancy and free counts SHALL be $clog2(FIFO_ELS)+1 bits, zero-extended to 32, ranging 0..FIFO_ELS.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_ELS.
REQ-026 pl_to_ps_ready_o SHALL equal not-full, registered-state only, with no combinational path from v_i.
REQ-027 ps_to_pl_v_o SHALL equal not-empty, with data_o the head entry.
REQ-028 Simultaneous push and pop on either FIFO SHALL both take effect and leave the count unchanged, including when full; on a full FIFO the push is admitted only if ready_o was 1 that cycle.
REQ-029 Read and write channels are independent and SHALL progress concurrently.
REQ-030 A same-cycle CSR write and read of the same CSR SHALL return the old value.

Reset
REQ-031 On aresetn=0, asynchronously, regardless of FSM state: FSMs to W_IDLE/R_IDLE; bvalid=rvalid=0; bresp=rresp=0; rdata=0; CSR0=CSR1=0; both FIFOs emptied.
REQ-032 During reset: awready=wready=arready=0, pl_to_ps_ready_o=0, ps_to_pl_v_o=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no response issued.
REQ-034 After aresetn deasserts, the first handshake SHALL be accepted at the first rising edge.

Verification
REQ-035 Write 0xA5A5_5A5A to 0x000 with wstrb=0x3, then read 0x000 -> bresp=0; rdata=0x0000_5A5A; csr_data_o[31:0]=0x0000_5A5A.
REQ-036 With FIFO_ELS=4: 5 writes to 0x008 with no yumi -> first 4 bresp=0, 5th bresp=2'b10; read 0x00C -> 0; ps_to_pl_v_o=1, data_o = 1st word.
REQ-037 Read 0x010 with pl_to_ps FIFO empty -> rdata=0, rresp=2'b10; push 0x1234 via PL, read 0x014 -> 1, read 0x010 -> 0x1234, rresp=0.
REQ-038 Fill pl_to_ps FIFO, then an AXI pop and a PL push in the same cycle -> occupancy stays 4, ready_o stays 0, FIFO order preserved.
REQ-039 Hold bready=0 for 10 cycles after a write -> bvalid held and bresp stable; meanwhile a read completes normally.
REQ-040 Assert aresetn=0 while rvalid=1 -> rvalid=0 immediately, CSRs=0, both FIFOs empty; then a new read of 0x014 -> 0.
